// File: rtl/hnf_rxreq_mp.sv
// Multi-port CHI REQ-channel receiver for the HN-F: per-link L-credit accounting,
// TgtID filtering, per-port posting queues and a round-robin merge onto one output stream.
module hnf_rxreq_mp #(
   parameter int unsigned NUM_PORTS = 2,
   parameter int unsigned FLIT_W    = 128,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned MAX_CRD   = 15,
   parameter int unsigned TGTID_LSB = 0,
   parameter int unsigned TGTID_W   = 7,
   parameter int unsigned MY_ID     = 0,
   localparam int unsigned SRC_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_PORTS*FLIT_W-1:0] RXREQFLIT,
   input  logic [NUM_PORTS-1:0]        RXREQFLITV,
   input  logic [NUM_PORTS-1:0]        RXREQFLITPEND,
   output logic [NUM_PORTS-1:0]        RXREQLCRDV,
   output logic [FLIT_W-1:0]           rxreq_first_entry,
   output logic                        rxreq_first_entry_valid,
   input  logic                        rxreq_first_entry_ready,
   output logic [SRC_W-1:0]            rxreq_first_entry_src,
   output logic                        err_tgtid,
   output logic                        err_nocrd,
   output logic [SRC_W-1:0]            err_port
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);
   localparam int unsigned CRD_W = $clog2(MAX_CRD + 1);
   localparam logic [TGTID_W-1:0] MY_TGT = TGTID_W'(MY_ID);

   logic [FLIT_W-1:0]    mem     [NUM_PORTS][DEPTH];
   logic [PTR_W-1:0]     wr_ptr  [NUM_PORTS];
   logic [PTR_W-1:0]     rd_ptr  [NUM_PORTS];
   logic [OCC_W-1:0]     occ     [NUM_PORTS];
   logic [CRD_W-1:0]     crd_out [NUM_PORTS];

   logic [NUM_PORTS-1:0] lcrdv_d;
   logic [NUM_PORTS-1:0] accept;
   logic [NUM_PORTS-1:0] wr_en;
   logic [NUM_PORTS-1:0] pop;
   logic [NUM_PORTS-1:0] nocrd;
   logic [NUM_PORTS-1:0] tgt_bad;

   logic [SRC_W-1:0]     rr_ptr;
   logic [SRC_W-1:0]     rr_next;
   logic [SRC_W-1:0]     sel;
   logic [SRC_W-1:0]     idx;
   logic                 any_valid;
   logic                 err_found;
   logic [SRC_W-1:0]     err_port_d;

   logic                 unused_pend;
   assign unused_pend = ^RXREQFLITPEND;

   // Credits in flight plus queued flits never exceed DEPTH, so an accepted flit always has a slot.
   always_comb begin
      lcrdv_d = '0;
      accept  = '0;
      wr_en   = '0;
      nocrd   = '0;
      tgt_bad = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         if ((32'(crd_out[p]) + 32'(occ[p]) + 32'(RXREQLCRDV[p]) < DEPTH) &&
             (32'(crd_out[p]) + 32'(RXREQLCRDV[p]) < MAX_CRD))
            lcrdv_d[p] = 1'b1;
         if (RXREQFLITV[p]) begin
            if (crd_out[p] == '0) begin
               nocrd[p] = 1'b1;
            end else begin
               accept[p] = 1'b1;
               if (RXREQFLIT[p*FLIT_W + TGTID_LSB +: TGTID_W] == MY_TGT)
                  wr_en[p] = 1'b1;
               else
                  tgt_bad[p] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      any_valid = 1'b0;
      sel       = rr_ptr;
      idx       = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         idx = SRC_W'((32'(rr_ptr) + i) % NUM_PORTS);
         if (!any_valid && (occ[idx] != '0)) begin
            any_valid = 1'b1;
            sel       = idx;
         end
      end
      pop = '0;
      if (any_valid && rxreq_first_entry_ready)
         pop[sel] = 1'b1;
      rr_next = (32'(sel) + 1 == NUM_PORTS) ? '0 : sel + 1'b1;
   end

   always_comb begin
      err_found  = 1'b0;
      err_port_d = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         if (!err_found && (nocrd[p] || tgt_bad[p])) begin
            err_found  = 1'b1;
            err_port_d = SRC_W'(p);
         end
      end
   end

   assign rxreq_first_entry       = mem[sel][rd_ptr[sel]];
   assign rxreq_first_entry_valid = any_valid;
   assign rxreq_first_entry_src   = sel;

   always_ff @(posedge clock) begin
      if (reset) begin
         RXREQLCRDV <= '0;
         rr_ptr     <= '0;
         err_tgtid  <= 1'b0;
         err_nocrd  <= 1'b0;
         err_port   <= '0;
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            crd_out[p] <= '0;
            occ[p]     <= '0;
            wr_ptr[p]  <= '0;
            rd_ptr[p]  <= '0;
         end
      end else begin
         RXREQLCRDV <= lcrdv_d;
         err_tgtid  <= |tgt_bad;
         err_nocrd  <= |nocrd;
         err_port   <= err_port_d;
         if (any_valid && rxreq_first_entry_ready)
            rr_ptr <= rr_next;
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            crd_out[p] <= crd_out[p] + CRD_W'(RXREQLCRDV[p]) - CRD_W'(accept[p]);
            occ[p]     <= occ[p] + OCC_W'(wr_en[p]) - OCC_W'(pop[p]);
            if (wr_en[p])
               wr_ptr[p] <= wr_ptr[p] + 1'b1;
            if (pop[p])
               rd_ptr[p] <= rd_ptr[p] + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++)
         if (wr_en[p])
            mem[p][wr_ptr[p]] <= RXREQFLIT[p*FLIT_W +: FLIT_W];
   end

endmodule

// File: tb/tb_hnf_rxreq_mp.sv
// Scoreboard bench for hnf_rxreq_mp: two ports, 16-bit flits, home node ID 5.
module tb_hnf_rxreq_mp;

   localparam int unsigned NP  = 2;
   localparam int unsigned FW  = 16;
   localparam int unsigned ID  = 5;
   localparam logic [6:0]  TID = 7'(ID);

   logic          clock = 1'b0;
   logic          reset;
   logic [NP*FW-1:0] flit_bus;
   logic [NP-1:0] flitv;
   logic [NP-1:0] pend;
   logic [NP-1:0] lcrdv;
   logic [FW-1:0] out_flit;
   logic          out_valid;
   logic          out_ready;
   logic          out_src;
   logic          err_tgtid;
   logic          err_nocrd;
   logic          err_port;

   int            checks = 0;
   int            errors = 0;
   int unsigned   grants [NP] = '{0, 0};
   int unsigned   used   [NP] = '{0, 0};
   int unsigned   g0;
   int unsigned   g1;
   logic [FW:0]   exp_q [$];
   logic [FW:0]   mon_e;

   initial forever #5 clock = ~clock;

   hnf_rxreq_mp #(
      .NUM_PORTS (NP),
      .FLIT_W    (FW),
      .DEPTH     (4),
      .MAX_CRD   (15),
      .TGTID_LSB (0),
      .TGTID_W   (7),
      .MY_ID     (ID)
   ) dut (
      .clock                   (clock),
      .reset                   (reset),
      .RXREQFLIT               (flit_bus),
      .RXREQFLITV              (flitv),
      .RXREQFLITPEND           (pend),
      .RXREQLCRDV              (lcrdv),
      .rxreq_first_entry       (out_flit),
      .rxreq_first_entry_valid (out_valid),
      .rxreq_first_entry_ready (out_ready),
      .rxreq_first_entry_src   (out_src),
      .err_tgtid               (err_tgtid),
      .err_nocrd               (err_nocrd),
      .err_port                (err_port)
   );

   function automatic logic [FW-1:0] mk(input logic [8:0] tag, input logic [6:0] tgt);
      return {tag, tgt};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic mid();
      @(negedge clock);
      #1;
   endtask

   task automatic send(input int p, input logic [8:0] tag, input logic [6:0] tgt, input bit expect_out);
      flit_bus[p*FW +: FW] = mk(tag, tgt);
      flitv[p] = 1'b1;
      used[p]++;
      if (expect_out)
         exp_q.push_back({1'(p), mk(tag, tgt)});
   endtask

   // Credit grant counter: the sender's view of credits received.
   always @(negedge clock) begin
      if (!reset)
         for (int p = 0; p < NP; p++)
            if (lcrdv[p])
               grants[p]++;
   end

   // Output monitor: every consumed flit must match the scoreboard head.
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected: got src %0d flit 0x%0h, expected nothing", out_src, out_flit);
         end else begin
            mon_e = exp_q.pop_front();
            if ({out_src, out_flit} !== mon_e) begin
               errors++;
               $display("FAIL out_flit: got src %0d flit 0x%0h, expected src %0d flit 0x%0h",
                        out_src, out_flit, mon_e[FW], mon_e[FW-1:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      reset     = 1'b1;
      flit_bus  = '0;
      flitv     = '0;
      pend      = '0;
      out_ready = 1'b0;
      repeat (3) cyc();
      mid();
      chk("rst_lcrdv", 32'(lcrdv), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_errs", 32'({err_tgtid, err_nocrd, err_port}), 0);

      // Reset release with a flit driven before any credit was granted
      cyc();
      reset = 1'b0;
      flit_bus[FW-1:0] = mk(9'h0A0, TID);
      flitv[0] = 1'b1;
      mid();
      chk("first_grant_delay", 32'(lcrdv), 0);
      cyc();
      flitv = '0;
      mid();
      chk("nocrd_pulse", 32'(err_nocrd), 1);
      chk("nocrd_port", 32'(err_port), 0);
      chk("nocrd_no_tgterr", 32'(err_tgtid), 0);
      chk("nocrd_not_queued", 32'(out_valid), 0);
      chk("first_grant", 32'(lcrdv), 32'h3);
      cyc();
      mid();
      chk("nocrd_pulse_end", 32'(err_nocrd), 0);
      repeat (8) cyc();
      mid();
      chk("init_grants_p0", grants[0], 4);
      chk("init_grants_p1", grants[1], 4);
      chk("init_grants_stop", 32'(lcrdv), 0);

      // Two flits on each port, then drain: round-robin p0,p1,p0,p1
      pend = '1;
      cyc();
      send(0, 9'h010, TID, 1'b1);
      send(1, 9'h020, TID, 1'b1);
      cyc();
      send(0, 9'h011, TID, 1'b1);
      send(1, 9'h021, TID, 1'b1);
      cyc();
      flitv = '0;
      pend  = '0;
      mid();
      chk("rr_valid", 32'(out_valid), 1);
      chk("rr_head_flit", 32'(out_flit), 32'(mk(9'h010, TID)));
      chk("rr_head_src", 32'(out_src), 0);
      cyc();
      out_ready = 1'b1;
      repeat (4) cyc();
      out_ready = 1'b0;
      repeat (8) cyc();
      mid();
      chk("rr_crd_p0", grants[0] - used[0], 4);
      chk("rr_crd_p1", grants[1] - used[1], 4);
      chk("rr_drained", 32'(exp_q.size()), 0);

      // Mis-targeted flit on port 1, then same-cycle grant/accept and push/pop
      cyc();
      send(1, 9'h030, 7'(ID + 1), 1'b0);
      cyc();
      flitv = '0;
      mid();
      chk("tgt_err", 32'(err_tgtid), 1);
      chk("tgt_port", 32'(err_port), 1);
      chk("tgt_no_nocrd", 32'(err_nocrd), 0);
      chk("tgt_not_queued", 32'(out_valid), 0);
      cyc();
      send(1, 9'h031, TID, 1'b1);
      out_ready = 1'b1;
      mid();
      chk("tgt_err_end", 32'(err_tgtid), 0);
      chk("tgt_regrant", 32'(lcrdv[1]), 1);
      cyc();
      send(1, 9'h032, TID, 1'b1);
      cyc();
      flitv = '0;
      repeat (8) cyc();
      out_ready = 1'b0;
      mid();
      chk("same_cyc_crd_p0", grants[0] - used[0], 4);
      chk("same_cyc_crd_p1", grants[1] - used[1], 4);
      chk("same_cyc_drained", 32'(exp_q.size()), 0);

      // Port 0 fills its queue with no ready: no new credits until drained
      g0 = grants[0];
      for (int k = 0; k < 4; k++) begin
         cyc();
         send(0, 9'(9'h040 + k), TID, 1'b1);
      end
      cyc();
      flitv = '0;
      repeat (3) cyc();
      mid();
      chk("full_no_grant", grants[0] - g0, 0);
      chk("full_lcrdv", 32'(lcrdv[0]), 0);
      chk("full_valid", 32'(out_valid), 1);
      chk("full_head_flit", 32'(out_flit), 32'(mk(9'h040, TID)));
      chk("full_head_src", 32'(out_src), 0);
      cyc();
      out_ready = 1'b1;
      repeat (4) cyc();
      out_ready = 1'b0;
      repeat (8) cyc();
      mid();
      chk("full_regrants", grants[0] - g0, 4);
      chk("full_crd_p0", grants[0] - used[0], 4);
      chk("full_drained", 32'(exp_q.size()), 0);

      // Reset with three queued flits
      for (int k = 0; k < 3; k++) begin
         cyc();
         send(0, 9'(9'h050 + k), TID, 1'b0);
      end
      cyc();
      flitv = '0;
      mid();
      chk("pre_rst_valid", 32'(out_valid), 1);
      cyc();
      reset = 1'b1;
      mid();
      chk("rst_edge_pending", 32'(out_valid), 1);
      cyc();
      mid();
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_lcrdv", 32'(lcrdv), 0);
      g0 = grants[0];
      g1 = grants[1];
      cyc();
      reset     = 1'b0;
      out_ready = 1'b1;
      repeat (10) cyc();
      mid();
      chk("retrain_p0", grants[0] - g0, 4);
      chk("retrain_p1", grants[1] - g1, 4);
      chk("post_rst_valid", 32'(out_valid), 0);
      chk("post_rst_errs", 32'({err_tgtid, err_nocrd}), 0);
      out_ready = 1'b0;

      cyc();
      mid();
      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
